// File: rtl/score_display_pkg.sv
// Shared game package: game state encodings, converter FSM states,
// colour constants and the 3x5 seven-segment style digit glyph ROM.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_GAME = 2'd1,
        ST_WAIT = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        CV_IDLE = 2'd0,
        CV_CONV = 2'd1,
        CV_LOAD = 2'd2
    } conv_state_t;

    localparam logic [2:0] COLOR_OFF   = 3'b000;
    localparam logic [2:0] COLOR_INIT  = 3'b001;
    localparam logic [2:0] COLOR_GLYPH = 3'b110;
    localparam logic [2:0] COLOR_BOX   = 3'b111;

    // Rows 0..4 are packed top to bottom, three bits each, leftmost column in
    // the most significant bit of its row.
    localparam logic [14:0] GLYPH_ROM [10] = '{
        15'b111_101_101_101_111,
        15'b001_001_001_001_001,
        15'b111_001_111_100_111,
        15'b111_001_111_001_111,
        15'b101_101_111_001_001,
        15'b111_100_111_001_111,
        15'b111_100_111_101_111,
        15'b111_001_001_001_001,
        15'b111_101_111_101_111,
        15'b111_101_111_001_111
    };

    // Returns whether the glyph cell at (row, col) of a decimal digit is lit;
    // non-decimal codes render blank.
    function automatic logic glyph_lit(input logic [3:0] digit,
                                       input logic [2:0] row,
                                       input logic [1:0] col);
        logic [3:0] bit_idx;
        bit_idx = 4'd14 - (4'(row) * 4'd3 + 4'(col));
        if (digit > 4'd9) begin
            return 1'b0;
        end
        return GLYPH_ROM[digit][bit_idx];
    endfunction

endpackage

// File: rtl/score_display_bin2bcd.sv
// Sequential double-dabble binary to BCD converter. A start pulse while idle
// latches the binary value; SCORE_W shift-add-3 steps follow, and done is
// high during the cycle whose edge performs the final step.
module bin2bcd
    import score_display_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter int DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(SCORE_W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(SCORE_W - 1);

    logic [SCORE_W-1:0]          shift_q;
    logic [CW-1:0]               step_q;
    logic [4*DIGITS-1:0]         bcd_adj;
    logic [4*DIGITS+SCORE_W-1:0] shifted;

    // One double-dabble step: bump every BCD digit of five or more by three,
    // then shift the whole BCD:binary pair left by one bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, shift_q} << 1;
    end

    assign done = busy && (step_q == LAST_STEP);

    // Latch the operand on start, then run exactly SCORE_W steps; a reset
    // throws away whatever partial result is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            step_q  <= '0;
            shift_q <= '0;
            bcd     <= '0;
        end else if (start && !busy) begin
            busy    <= 1'b1;
            step_q  <= '0;
            shift_q <= bin;
            bcd     <= '0;
        end else if (busy) begin
            {bcd, shift_q} <= shifted;
            step_q         <= step_q + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/score_display.sv
// Score box renderer: converts the binary score to decimal digits in the
// background, draws them as scaled 3x5 glyphs inside a strict-edged box, and
// blinks the digits while the game is in WAIT.
module score_display
    import score_display_pkg::*;
#(
    parameter int X0           = 440,
    parameter int Y0           = 20,
    parameter int BOX_W        = 150,
    parameter int BOX_H        = 110,
    parameter int SCORE_W      = 8,
    parameter int DIGITS       = 3,
    parameter int SCALE        = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_tick,
    input  logic [SCORE_W-1:0] score,
    input  logic [1:0]         state,
    output logic [2:0]         rgb,
    output logic               busy
);

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] LAST_FRAME = BW'(BLINK_FRAMES - 1);

    conv_state_t         fsm;
    logic [SCORE_W-1:0]  last_converted;
    logic [SCORE_W-1:0]  pending_score;
    logic [4*DIGITS-1:0] disp_digits;
    logic [4*DIGITS-1:0] conv_bcd;
    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic [BW-1:0]       blink_cnt;
    logic                blink_on;
    logic                in_box;
    logic                is_init;
    logic                lit;

    assign conv_start = (fsm == CV_IDLE) && (score != last_converted) && !conv_busy;

    bin2bcd #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Conversion sequencing: start on a score mismatch, wait out the
    // converter, then publish its digits and remember which score they show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm            <= CV_IDLE;
            busy           <= 1'b0;
            last_converted <= '0;
            pending_score  <= '0;
            disp_digits    <= '0;
        end else begin
            case (fsm)
                CV_IDLE: begin
                    if (conv_start) begin
                        fsm           <= CV_CONV;
                        busy          <= 1'b1;
                        pending_score <= score;
                    end
                end
                CV_CONV: begin
                    if (conv_done) begin
                        fsm <= CV_LOAD;
                    end
                end
                CV_LOAD: begin
                    disp_digits    <= conv_bcd;
                    last_converted <= pending_score;
                    fsm            <= CV_IDLE;
                    busy           <= 1'b0;
                end
                default: begin
                    fsm  <= CV_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // Blink phase: count frames only while waiting, flipping visibility every
    // BLINK_FRAMES frames; any other game state parks the digits visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state != ST_WAIT) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == LAST_FRAME) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Pixel classification: strict box test, INIT decode (code 3 counts as
    // INIT) and glyph hit test with leading zeros suppressed.
    always_comb begin
        int  xi;
        int  yi;
        int  dx;
        int  dy;
        logic [3:0] d;
        logic shown;
        xi      = {22'd0, x};
        yi      = {22'd0, y};
        dx      = 0;
        dy      = 0;
        d       = '0;
        shown   = 1'b0;
        lit     = 1'b0;
        in_box  = (xi > X0) && (xi < X0 + BOX_W) && (yi > Y0) && (yi < Y0 + BOX_H);
        is_init = !((state == ST_GAME) || (state == ST_WAIT));
        for (int i = 0; i < DIGITS; i++) begin
            d = disp_digits[4*(DIGITS-1-i) +: 4];
            if (d != 4'd0) begin
                shown = 1'b1;
            end
            dx = xi - (X0 + SCALE + i * 4 * SCALE);
            dy = yi - (Y0 + SCALE);
            if ((shown || (i == DIGITS - 1)) && (dx >= 0) && (dx < 3 * SCALE) &&
                (dy >= 0) && (dy < 5 * SCALE)) begin
                lit = lit | glyph_lit(d, 3'(dy / SCALE), 2'(dx / SCALE));
            end
        end
    end

    // Registered colour output in priority order: outside, INIT fill,
    // visible glyph, plain box background.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= COLOR_OFF;
        end else if (!in_box) begin
            rgb <= COLOR_OFF;
        end else if (is_init) begin
            rgb <= COLOR_INIT;
        end else if (lit && ((state != ST_WAIT) || blink_on)) begin
            rgb <= COLOR_GLYPH;
        end else begin
            rgb <= COLOR_BOX;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model built from decimal arithmetic and segment geometry.
module tb_score_display;

    localparam int X0      = 440;
    localparam int Y0      = 20;
    localparam int BOX_W   = 150;
    localparam int BOX_H   = 110;
    localparam int SCORE_W = 8;
    localparam int DIGITS  = 3;
    localparam int SCALE   = 8;
    localparam int BF      = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       frame_tick = 1'b0;
    logic [7:0] score = '0;
    logic [1:0] state = 2'd1;
    logic [2:0] rgb;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    int m_disp   = 0;
    int m_last   = 0;
    int m_pend   = 0;
    int m_left   = 0;
    int m_wticks = 0;
    int exp_rgb  = 0;
    int exp_busy;

    score_display #(
        .X0(X0), .Y0(Y0), .BOX_W(BOX_W), .BOX_H(BOX_H),
        .SCORE_W(SCORE_W), .DIGITS(DIGITS), .SCALE(SCALE), .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .score      (score),
        .state      (state),
        .rgb        (rgb),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Seven-segment geometry on a 3x5 cell grid, segments a..g in bits 6..0.
    function automatic bit seg_pixel(input int d, input int row, input int col);
        logic [6:0] s;
        case (d)
            0: s = 7'b1111110;
            1: s = 7'b0110000;
            2: s = 7'b1101101;
            3: s = 7'b1111001;
            4: s = 7'b0110011;
            5: s = 7'b1011011;
            6: s = 7'b1011111;
            7: s = 7'b1110000;
            8: s = 7'b1111111;
            default: s = 7'b1111011;
        endcase
        return (s[6] && row == 0) || (s[5] && col == 2 && row <= 2) ||
               (s[4] && col == 2 && row >= 2) || (s[3] && row == 4) ||
               (s[2] && col == 0 && row >= 2) || (s[1] && col == 0 && row <= 2) ||
               (s[0] && row == 2);
    endfunction

    function automatic int model_rgb(input int xv, input int yv, input int st,
                                     input int disp, input bit on);
        bit hit = 0;
        if (!(xv > X0 && xv < X0 + BOX_W && yv > Y0 && yv < Y0 + BOX_H)) return 0;
        if (st == 0 || st == 3) return 1;
        for (int i = 0; i < DIGITS; i++) begin
            int place = pow10(DIGITS - 1 - i);
            int d     = (disp / place) % 10;
            int ox    = X0 + SCALE + i * 4 * SCALE;
            int oy    = Y0 + SCALE;
            bit show  = (i == DIGITS - 1) || (disp >= place);
            if (show && xv >= ox && xv < ox + 3 * SCALE && yv >= oy && yv < oy + 5 * SCALE)
                hit = hit | seg_pixel(d, (yv - oy) / SCALE, (xv - ox) / SCALE);
        end
        if (hit && (st != 2 || on)) return 6;
        return 7;
    endfunction

    // Reference model: a conversion occupies SCORE_W+1 busy cycles and then
    // shows the sampled score; blink phase follows the count of WAIT frames.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_disp   <= 0;
            m_last   <= 0;
            m_pend   <= 0;
            m_left   <= 0;
            m_wticks <= 0;
            exp_rgb  <= 0;
        end else begin
            exp_rgb <= model_rgb(int'(x), int'(y), int'(state), m_disp, ((m_wticks / BF) % 2) == 0);
            if (m_left == 0) begin
                if (int'(score) != m_last) begin
                    m_pend <= int'(score);
                    m_left <= SCORE_W + 1;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_disp <= m_pend;
                    m_last <= m_pend;
                end
            end
            m_wticks <= (state != 2'd2) ? 0 : m_wticks + int'(frame_tick);
        end
    end

    assign exp_busy = (m_left != 0) ? 1 : 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of the outputs against the model.
    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            checkOutput("model_rgb", int'(rgb), exp_rgb);
            checkOutput("model_busy", int'(busy), exp_busy);
        end
    end

    task automatic applyStimulus(input int xv, input int yv, input int st, input int sc, input int ft);
        @(negedge clk);
        x          = 10'(xv);
        y          = 10'(yv);
        state      = 2'(st);
        score      = 8'(sc);
        frame_tick = ft[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitIdle(input string name);
        for (int k = 0; k < 40 && busy; k++) tick();
        checkOutput(name, int'(busy), 0);
    endtask

    initial begin
        int cnt;
        int t12;
        int t200;
        int bad;
        int dv;
        int sc;
        int st;

        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rgb", int'(rgb), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_digits", int'(dut.disp_digits), 0);
        applyStimulus(448, 28, 1, 0, 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick();
        checkOutput("zero_digit0_blank", int'(rgb), 7);

        // 255: nine busy cycles, digits 2,5,5 in cycle 10, first glyph lit
        applyStimulus(448, 28, 1, 255, 0);
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (busy) cnt++;
        end
        checkOutput("busy_cycles_255", cnt, 9);
        checkOutput("digits_255", int'(dut.disp_digits), 'h255);
        tick();
        checkOutput("glyph_origin_255", int'(rgb), 6);

        // 7: two leading zeros blanked, last digit drawn
        applyStimulus(448, 28, 1, 7, 0);
        tick();
        waitIdle("idle_after_7");
        applyStimulus(448, 28, 1, 7, 0);
        tick();
        checkOutput("digit0_blank_7", int'(rgb), 7);
        applyStimulus(480, 28, 1, 7, 0);
        tick();
        checkOutput("digit1_blank_7", int'(rgb), 7);
        applyStimulus(512, 28, 1, 7, 0);
        tick();
        checkOutput("digit2_lit_7", int'(rgb), 6);

        // 12 then 200 arriving mid-conversion
        applyStimulus(512, 28, 1, 12, 0);
        repeat (3) tick();
        applyStimulus(512, 28, 1, 200, 0);
        t12 = -1;
        t200 = -1;
        bad = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            dv = int'(dut.disp_digits);
            if (dv == 'h012 && t12 < 0) t12 = k;
            if (dv == 'h200 && t200 < 0) t200 = k;
            if (dv != 'h007 && dv != 'h012 && dv != 'h200) bad++;
        end
        checkOutput("load_time_12", t12, 7);
        checkOutput("reload_gap_200", t200 - t12, SCORE_W + 2);
        checkOutput("no_corrupt_digits", bad, 0);

        // reset in the middle of converting 99
        applyStimulus(512, 28, 1, 99, 0);
        repeat (4) tick();
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midconv_reset_rgb", int'(rgb), 0);
        checkOutput("midconv_reset_busy", int'(busy), 0);
        checkOutput("midconv_reset_digits", int'(dut.disp_digits), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5 && !busy; k++) tick();
        checkOutput("restart_after_reset", int'(busy), 1);
        waitIdle("idle_after_restart");
        checkOutput("digits_99", int'(dut.disp_digits), 'h099);

        // blinking in WAIT, relit immediately on GAME
        applyStimulus(512, 28, 2, 99, 0);
        for (int n = 1; n <= 150; n++) begin
            applyStimulus(512, 28, 2, 99, 1);
            applyStimulus(512, 28, 2, 99, 0);
            tick();
            if (n == 29 || (n % 30) == 0)
                checkOutput($sformatf("blink_after_%0d", n), int'(rgb), ((n / 30) % 2 == 0) ? 6 : 7);
            repeat ($urandom_range(0, 2)) tick();
        end
        applyStimulus(512, 28, 1, 99, 0);
        tick();
        checkOutput("game_relit", int'(rgb), 6);

        // strict box edges and INIT fill
        applyStimulus(440, 50, 1, 99, 0);
        tick();
        checkOutput("edge_left", int'(rgb), 0);
        applyStimulus(590, 50, 1, 99, 0);
        tick();
        checkOutput("edge_right", int'(rgb), 0);
        applyStimulus(500, 20, 1, 99, 0);
        tick();
        checkOutput("edge_top", int'(rgb), 0);
        applyStimulus(500, 130, 1, 99, 0);
        tick();
        checkOutput("edge_bottom", int'(rgb), 0);
        applyStimulus(441, 21, 0, 99, 0);
        tick();
        checkOutput("init_corner", int'(rgb), 1);

        // randomized traffic, checked by the model every cycle
        sc = 99;
        st = 1;
        for (int c = 0; c < 3000; c++) begin
            int xv;
            int yv;
            if ($urandom_range(0, 1) == 0) begin
                xv = $urandom_range(440, 540);
                yv = $urandom_range(20, 70);
            end else begin
                xv = $urandom_range(420, 610);
                yv = $urandom_range(0, 150);
            end
            if ($urandom_range(0, 19) == 0) sc = $urandom_range(0, 255);
            if ($urandom_range(0, 299) == 0) st = $urandom_range(0, 3);
            applyStimulus(xv, yv, st, sc, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
